// File: rtl/stream_decipher.sv
// rtl/stream_decipher.sv - LFSR stream decipher: sync-header check, payload decrypt, one-entry output register
module stream_decipher #(
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    parameter int         FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       sync_err,
    output logic [3:0] key_stream
);

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    localparam logic [3:0] KEY_K0   = 4'b0001;
    localparam logic [3:0] KEY_K1   = 4'b0011;
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t     state_q, state_d;
    logic [3:0] lfsr_q, lfsr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_last_q, out_last_d;
    logic       sync_err_q, sync_err_d;

    logic       accept;
    logic       header_ok;
    logic [3:0] lfsr_next;

    assign in_ready   = (state_q == IDLE) | ~out_valid_q | out_ready;
    assign accept     = in_valid & in_ready;
    // The header is always enciphered with K0, i.e. XOR 8'h11.
    assign header_ok  = ((in_data ^ {KEY_K0, KEY_K0}) == SYNC_WORD);
    assign lfsr_next  = {lfsr_q[2:0], lfsr_q[0] ^ lfsr_q[3]};

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign sync_err   = sync_err_q;
    assign key_stream = lfsr_q;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sync_err_d  = 1'b0;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (in_sof) begin
                // A header inside a frame aborts it; a pending output byte still drains.
                sync_err_d = (state_q == PAYLOAD) | ~header_ok;
                cnt_d      = 8'd0;
                if (header_ok) begin
                    lfsr_d  = KEY_K1;
                    state_d = PAYLOAD;
                end else begin
                    lfsr_d  = KEY_K0;
                    state_d = IDLE;
                end
            end else if (state_q == PAYLOAD) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data ^ {lfsr_q, lfsr_q};
                lfsr_d      = lfsr_next;
                if (cnt_q == LAST_IDX) begin
                    out_last_d = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = IDLE;
                end else begin
                    out_last_d = 1'b0;
                    cnt_d      = cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            lfsr_q      <= KEY_K0;
            cnt_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sync_err_q  <= sync_err_d;
        end
    end

endmodule

// File: tb/tb_stream_decipher.sv
// tb/tb_stream_decipher.sv - directed self-checking bench for stream_decipher
module tb_stream_decipher;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_data;
    logic       out_ready;
    logic       sel20;

    logic       in_ready, out_valid, out_last, sync_err;
    logic [7:0] out_data;
    logic [3:0] key_stream;
    logic       in_ready20, out_valid20, out_last20, sync_err20;
    logic [7:0] out_data20;
    logic [3:0] key_stream20;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] keys [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                              4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

    always #5 clk = ~clk;

    stream_decipher #(.SYNC_WORD(8'hA5), .FRAME_LEN(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid & ~sel20), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sync_err(sync_err), .key_stream(key_stream)
    );

    stream_decipher #(.SYNC_WORD(8'hA5), .FRAME_LEN(20)) dut20 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid & sel20), .in_ready(in_ready20), .in_data(in_data), .in_sof(in_sof),
        .out_valid(out_valid20), .out_ready(out_ready), .out_data(out_data20), .out_last(out_last20),
        .sync_err(sync_err20), .key_stream(key_stream20)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] k;
        logic [7:0] p;
        reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
        out_ready = 1'b1; sel20 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_last", out_last, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_key", key_stream, 4'h1);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b1;

        send(8'hB4, 1'b1);
        chk("hdr_key", key_stream, 4'h3);
        chk("hdr_no_out", out_valid, 0);
        chk("hdr_no_err", sync_err, 0);
        for (int i = 0; i < 16; i++) begin
            k = keys[(i + 1) % 15];
            send({k, k}, 1'b0);
            chk("f16_valid", out_valid, 1);
            chk("f16_data", out_data, 8'h00);
            chk("f16_last", out_last, (i == 15));
            chk("f16_err", sync_err, 0);
        end
        idle_cycle();
        chk("f16_drained", out_valid, 0);
        send(8'h33, 1'b0);
        chk("idle_discard", out_valid, 0);

        send(8'h00, 1'b1);
        chk("bad_hdr_err", sync_err, 1);
        chk("bad_hdr_no_out", out_valid, 0);
        chk("bad_hdr_key", key_stream, 4'h1);
        idle_cycle();
        chk("bad_hdr_pulse_end", sync_err, 0);
        send(8'h33, 1'b0);
        chk("bad_hdr_discard", out_valid, 0);

        send(8'hB4, 1'b1);
        send(8'h33, 1'b0);
        chk("bp_first_data", out_data, 8'h00);
        chk("bp_first_key", key_stream, 4'h7);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", in_ready, 0);
        in_valid = 1'b1; in_data = 8'h77; in_sof = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 8'h00);
            chk("bp_hold_key", key_stream, 4'h7);
        end
        out_ready = 1'b1;
        idle_cycle();
        in_valid = 1'b0;
        chk("bp_resume_valid", out_valid, 1);
        chk("bp_resume_data", out_data, 8'h00);
        chk("bp_resume_key", key_stream, 4'hF);
        send(8'hFF, 1'b0);
        chk("bp_b2_data", out_data, 8'h00);
        send(8'hEE, 1'b0);
        chk("bp_b3_data", out_data, 8'h00);
        send(8'hDD, 1'b0);
        chk("bp_b4_data", out_data, 8'h00);
        chk("bp_b4_key", key_stream, 4'hA);

        send(8'hB4, 1'b1);
        chk("resync_err", sync_err, 1);
        chk("resync_key", key_stream, 4'h3);
        chk("resync_no_out", out_valid, 0);
        send(8'h3C, 1'b0);
        chk("resync_data", out_data, 8'h0F);
        chk("resync_valid", out_valid, 1);
        chk("resync_err_end", sync_err, 0);

        out_ready = 1'b0;
        reset = 1'b0;
        idle_cycle();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_key", key_stream, 4'h1);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_data", out_data, 8'h00);
        reset = 1'b1;
        out_ready = 1'b1;

        sel20 = 1'b1;
        send(8'hB4, 1'b1);
        for (int i = 0; i < 20; i++) begin
            k = keys[(i + 1) % 15];
            p = 8'(8'h40 + i);
            if (i == 14) chk("f20_wrap_key", key_stream20, 4'h1);
            send(p ^ {k, k}, 1'b0);
            chk("f20_data", out_data20, p);
            chk("f20_last", out_last20, (i == 19));
        end
        chk("f20_other_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
